controle_multiciclo: RTL
========================

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 opcode  input  7  instr[6:0] from instruction register, valid from DECODE onward.
REQ-004 mem_ready  input  1  memory handshake; access completes in a cycle with mem_ready=1.
REQ-005 pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write  output  1 each  datapath strobes.
REQ-006 i_or_d  output  1  memory address select: 0 PC, 1 ALU result register.
REQ-007 mem_to_reg  output  1  writeback select: 0 ALU result, 1 memory data.
REQ-008 alu_src_a  output  1  0 old PC, 1 register A.
REQ-009 alu_src_b  output  2  00 register B, 01 constant 4, 10 immediate, 11 immediate<<1.
REQ-010 alu_op  output  2  00 add, 01 sub, 10 R-type (decode funct), 11 and; consumed by Unidade_Controle_ULA.
REQ-011 pc_source  output  1  0 ALU output, 1 ALU result register.
REQ-012 state_o  output  4  current state encoding, debug.
REQ-013 retired  output  16  retired-instruction count.
REQ-014 illegal_instr  output  1  sticky illegal-opcode flag (only with ILLEGAL_TRAP_EN).

Function
REQ-015 Moore FSM; outputs decoded from state_q only, except FETCH/MEM_READ/MEM_WRITE completion strobes gated by mem_ready; every strobe not listed for a state SHALL be 0.
REQ-016 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=0; ir_write=pc_write=1 only when mem_ready=1; holds until mem_ready=1, then DECODE.
REQ-017 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target); next: 0000011/0100011 MEM_ADDR, 0110011 EXEC_R, 0010011 EXEC_I, 1100011 BRANCH, other ILLEGAL path (REQ-029).
REQ-018 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; lh to MEM_READ, sh to MEM_WRITE.
REQ-019 MEM_READ: mem_read=1, i_or_d=1; holds until mem_ready=1, then MEM_WB.
REQ-020 MEM_WB: reg_write=1, mem_to_reg=1; then FETCH.
REQ-021 MEM_WRITE: mem_write=1, i_or_d=1; holds until mem_ready=1, then FETCH.
REQ-022 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=11; both to ALU_WB.
REQ-023 ALU_WB: reg_write=1, mem_to_reg=0; then FETCH.
REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1; then FETCH.
REQ-025 Latency with mem_ready held 1: lh 5, sh 4, R/andi 4, beq 3 cycles FETCH-to-FETCH.
REQ-026 retired increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB, BRANCH; wraps 0xFFFF to 0x0000.
REQ-027 opcode sampled only in DECODE; changes in other states SHALL have no effect.

Reset
REQ-028 rst_n=0 SHALL immediately set state_q=FETCH, retired=0, illegal_instr=0, and force all strobes to 0 regardless of state; mid-instruction reset aborts with no write strobe asserted; FETCH begins on first edge after release.

Configuration
REQ-029 Macro CONTROLE_ILLEGAL_TRAP_EN defined: unknown opcode in DECODE enters TRAP, sets illegal_instr=1, all strobes 0, remains until reset. Undefined: unknown opcode returns DECODE to FETCH as NOP, not counted in retired; illegal_instr tied 0, TRAP absent.

Structure
REQ-030 Package controle_pkg SHALL hold state encodings, opcode constants, alu_op codes (00/01/10/11), alu_src_b codes.
REQ-031 One sub-module decodificador_opcode: combinational opcode-to-instruction-class decode used by DECODE transition logic.

Verification
REQ-032 Reset mid-MEM_WRITE with mem_ready=1 -> mem_write=0 during reset, state_o=FETCH, retired=0.
REQ-033 opcode=0110011, mem_ready=1 -> states FETCH,DECODE,EXEC_R,ALU_WB; alu_op=10 in EXEC_R; reg_write=1 one cycle; retired +1.
REQ-034 opcode=0000011, mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles, then MEM_WB with mem_to_reg=1.
REQ-035 opcode=1100011 -> BRANCH with alu_op=01, pc_write_cond=1, pc_source=1 for exactly 1 cycle.
REQ-036 0x10000 retirements of andi -> retired wraps to 0x0000; alu_op=11 in each EXEC_I.
REQ-037 opcode=1111111 -> with macro: TRAP, illegal_instr=1 until reset; without: back to FETCH, retired unchanged.

Source files
------------

// File: rtl/controle_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// alu_op and alu_src_b codes, and the instruction classes from the opcode decoder.
// Latency: n/a (constants only). Backpressure: n/a.
package controle_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_TRAP      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_AND   = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH1 = 2'b11;

  typedef enum logic [2:0] {
    CL_LOAD,
    CL_STORE,
    CL_RTYPE,
    CL_ITYPE,
    CL_BRANCH,
    CL_ILLEGAL
  } instr_class_t;

endpackage

// File: rtl/decodificador_opcode.sv
// Opcode to instruction-class decoder feeding the DECODE-state transition.
// Latency: combinational. Backpressure: none.
// Ports: opcode (instr[6:0]) in, classe (instr_class_t) out.
module decodificador_opcode
  import controle_pkg::*;
(
  input  logic [6:0]   opcode,
  output instr_class_t classe
);

  always_comb begin
    classe = CL_ILLEGAL;
    case (opcode)
      OP_LOAD:   classe = CL_LOAD;
      OP_STORE:  classe = CL_STORE;
      OP_RTYPE:  classe = CL_RTYPE;
      OP_ITYPE:  classe = CL_ITYPE;
      OP_BRANCH: classe = CL_BRANCH;
      default:   classe = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Moore control FSM for a multicycle datapath (lh/sh/R-type/andi/beq) plus retired counter.
// Latency: lh 5, sh 4, R/andi 4, beq 3 cycles; FETCH/MEM_READ/MEM_WRITE stall while mem_ready=0.
// Ports: clk, rst_n (async low), opcode, mem_ready in; datapath strobes/selects, state_o,
//        retired, illegal_instr out. CONTROLE_ILLEGAL_TRAP_EN: unknown opcode traps (sticky flag).
module controle_multiciclo
  import controle_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        i_or_d,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        pc_source,
  output logic [3:0]  state_o,
  output logic [15:0] retired,
  output logic        illegal_instr
);

  state_t       state_q, state_d;
  instr_class_t classe;
  logic         is_store_q;   // load/store choice captured in DECODE; opcode is ignored later
  logic         retire;
  logic [15:0]  retired_q;

  decodificador_opcode u_dec (
    .opcode (opcode),
    .classe (classe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      is_store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) is_store_q <= (classe == CL_STORE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (classe)
          CL_LOAD, CL_STORE: state_d = S_MEM_ADDR;
          CL_RTYPE:          state_d = S_EXEC_R;
          CL_ITYPE:          state_d = S_EXEC_I;
          CL_BRANCH:         state_d = S_BRANCH;
`ifdef CONTROLE_ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;   // unknown opcode retires nothing
`endif
        endcase
      end
      S_MEM_ADDR:  state_d = is_store_q ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_ALU_WB;
      S_EXEC_I:    state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
`ifdef CONTROLE_ILLEGAL_TRAP_EN
      S_TRAP:      state_d = S_TRAP;
`endif
      default:     state_d = S_FETCH;
    endcase
  end

  // Outputs depend on state_q only (plus mem_ready for FETCH completion).
  // rst_n gates them so strobes drop the instant reset asserts.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    i_or_d        = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:    alu_src_b = SRCB_IMM_SH1;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_RTYPE;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_AND;
        end
        S_ALU_WB:    reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign retire = (state_q == S_MEM_WB) || (state_q == S_ALU_WB) || (state_q == S_BRANCH) ||
                  ((state_q == S_MEM_WRITE) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired_q <= 16'h0000;
    else if (retire) retired_q <= retired_q + 16'h0001;   // wraps naturally
  end

`ifdef CONTROLE_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  illegal_q <= 1'b0;
    else if (state_d == S_TRAP)  illegal_q <= 1'b1;
  end
  assign illegal_instr = illegal_q;
`else
  assign illegal_instr = 1'b0;
`endif

  assign state_o = state_q;
  assign retired = retired_q;

endmodule
